// File: rtl/team_06_delay_buffer_ctrl.sv
// Delay-memory responder for the echo/reverb effect. Each record stores one sample
// into a circular buffer in external SRAM. With search set, the sample DELAY slots
// back is then read and returned on past_output with a goodData pulse.
module team_06_delay_buffer_ctrl #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned DELAY     = 2000,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  SILENCE   = 8'd128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              record,
  input  logic              search,
  input  logic [7:0]        save_audio,
  input  logic              flush,
  output logic [7:0]        past_output,
  output logic              goodData,
  output logic              busy,
  output logic              dropped,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              srch_q, srch_d;
  logic              flush_pend_q, flush_pend_d;
  logic [7:0]        past_q, past_d;
  logic              good_q, good_d;
  logic              drop_q, drop_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic [PTR_W-1:0]  rptr;
  logic              fill_ge;

  // Map a buffer slot to its SRAM byte address.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [PTR_W-1:0] p);
    logic [31:0] a;
    a = BASE_ADDR + 32'(p);
    return a[ADDR_W-1:0];
  endfunction

  assign fill_ge = (32'(fill_q) >= DELAY);

  // Read slot is DELAY behind the write slot; DEPTH need not be a power of two.
  always_comb begin
    if (32'(wptr_q) >= DELAY) begin
      rptr = PTR_W'(32'(wptr_q) - DELAY);
    end else begin
      rptr = PTR_W'(32'(wptr_q) + DEPTH - DELAY);
    end
  end

  // Next-state logic for the write / optional read / done sequence.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    fill_d       = fill_q;
    srch_d       = srch_q;
    flush_pend_d = flush_pend_q;
    past_d       = past_q;
    good_d       = 1'b0;
    drop_d       = 1'b0;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          // Flush wins over a coincident record.
          wptr_d = '0;
          fill_d = '0;
          past_d = SILENCE;
          drop_d = record;
        end else if (record) begin
          wdata_d      = save_audio;
          srch_d       = search;
          flush_pend_d = 1'b0;
          req_d        = 1'b1;
          we_d         = 1'b1;
          addr_d       = slot_addr(wptr_q);
          state_d      = S_WRITE;
        end
      end
      S_WRITE: begin
        drop_d = record;
        if (flush) flush_pend_d = 1'b1;
        if (mem_ack) begin
          if (srch_q && fill_ge) begin
            we_d    = 1'b0;
            addr_d  = slot_addr(rptr);
            state_d = S_READ;
          end else begin
            req_d   = 1'b0;
            good_d  = srch_q;
            if (srch_q) past_d = SILENCE;
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        drop_d = record;
        if (flush) flush_pend_d = 1'b1;
        if (mem_ack) begin
          req_d   = 1'b0;
          past_d  = mem_rdata;
          good_d  = srch_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        drop_d = record;
        // A flush seen during the transaction replaces the pointer advance.
        if (flush_pend_q || flush) begin
          wptr_d = '0;
          fill_d = '0;
        end else begin
          wptr_d = (32'(wptr_q) == DEPTH - 1) ? '0 : wptr_q + PTR_W'(1);
          fill_d = (32'(fill_q) == DEPTH) ? fill_q : fill_q + FILL_W'(1);
        end
        flush_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; async reset drops the bus request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      fill_q       <= '0;
      srch_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      past_q       <= SILENCE;
      good_q       <= 1'b0;
      drop_q       <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      fill_q       <= fill_d;
      srch_q       <= srch_d;
      flush_pend_q <= flush_pend_d;
      past_q       <= past_d;
      good_q       <= good_d;
      drop_q       <= drop_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign past_output = past_q;
  assign goodData    = good_q;
  assign busy        = (state_q != S_IDLE);
  assign dropped     = drop_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_team_06_delay_buffer_ctrl.sv
// Randomised bench for the delay buffer controller against a sample-history model.
module tb_team_06_delay_buffer_ctrl;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DELAY  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              record = 1'b0;
  logic              search = 1'b0;
  logic [7:0]        save_audio = 8'd0;
  logic              flush = 1'b0;
  logic [7:0]        past_output;
  logic              goodData;
  logic              busy;
  logic              dropped;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  always #5 clk = ~clk;

  team_06_delay_buffer_ctrl #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .DELAY    (DELAY),
    .BASE_ADDR(0),
    .SILENCE  (8'd128)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .record     (record),
    .search     (search),
    .save_audio (save_audio),
    .flush      (flush),
    .past_output(past_output),
    .goodData   (goodData),
    .busy       (busy),
    .dropped    (dropped),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // SRAM model with programmable ack latency; logs every completed access.
  logic [7:0] sram [0:255];
  int         ack_delay = 0;
  int         wait_cnt  = 0;
  logic       stray_ack = 1'b0;
  int         wr_addr_q[$];
  int         wr_data_q[$];
  int         rd_addr_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ack   <= 1'b0;
      mem_rdata <= 8'd0;
      wait_cnt  <= 0;
    end else begin
      mem_ack <= stray_ack;
      if (mem_req && !mem_ack) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  <= 1'b1;
          wait_cnt <= 0;
          if (mem_we) begin
            sram[mem_addr[7:0]] <= mem_wdata;
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(int'(mem_wdata));
          end else begin
            mem_rdata <= sram[mem_addr[7:0]];
            rd_addr_q.push_back(int'(mem_addr));
          end
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  // Bus must stay frozen while a request waits for its ack.
  logic [24:0] prev_bus = '0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  always @(negedge clk) begin
    if (!rst && mem_req && prev_req && !prev_ack)
      check_val("bus_stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(prev_bus));
    prev_bus <= {mem_we, mem_addr, mem_wdata};
    prev_req <= mem_req;
    prev_ack <= mem_ack;
  end

  // Reference model: every sample written since the last flush, in order.
  logic [7:0] hist[$];
  logic [7:0] exp_past = 8'd128;

  task automatic do_record(input logic [7:0] d, input logic s, input int second_at,
                           input bit flush_in_read);
    int   n, lat, goods, drops, wa, ra;
    bit   rd, done, flushed;
    n  = hist.size();
    rd = s && (n >= DELAY);
    wa = n % DEPTH;
    ra = rd ? (n - DELAY) % DEPTH : 0;
    if (s) exp_past = rd ? hist[n - DELAY] : 8'd128;
    hist.push_back(d);
    @(negedge clk);
    record = 1'b1; save_audio = d; search = s;
    lat = 0; goods = 0; drops = 0; done = 0; flushed = 0;
    for (int i = 1; i <= 60 && !done; i++) begin
      @(negedge clk);
      record = (i == second_at);
      if (record) save_audio = ~d;
      flush = 1'b0;
      if (goodData) begin goods++; lat = i; end
      if (dropped) drops++;
      if (flush_in_read && !flushed && mem_req && !mem_we) begin
        flush = 1'b1; flushed = 1;
      end
      if (!busy) done = 1;
    end
    record = 1'b0;
    if (!done) check_val("timeout", 0, 1);
    check_val("good_cnt", goods, s ? 1 : 0);
    check_val("past", past_output, exp_past);
    check_val("drop_cnt", drops, (second_at > 0) ? 1 : 0);
    if (s && ack_delay == 0) check_val("latency", lat, rd ? 5 : 3);
    check_val("wr_cnt", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      check_val("wr_addr", wr_addr_q.pop_front(), wa);
      check_val("wr_data", wr_data_q.pop_front(), d);
    end
    check_val("rd_cnt", rd_addr_q.size(), rd ? 1 : 0);
    if (rd_addr_q.size() > 0) check_val("rd_addr", rd_addr_q.pop_front(), ra);
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    if (flushed) hist.delete();
  endtask

  task automatic do_flush(input logic with_record);
    @(negedge clk);
    flush = 1'b1; record = with_record; save_audio = 8'h77; search = 1'b1;
    @(negedge clk);
    flush = 1'b0; record = 1'b0;
    check_val("flush_drop", dropped, with_record);
    check_val("flush_past", past_output, 128);
    @(negedge clk);
    check_val("flush_idle", {busy, mem_req}, 0);
    check_val("flush_nowr", wr_addr_q.size(), 0);
    hist.delete();
    exp_past = 8'd128;
  endtask

  initial begin
    int req_seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) req_seen++;
    end
    check_val("rst_req", req_seen, 0);
    check_val("rst_past", past_output, 128);
    check_val("rst_flags", {goodData, busy, dropped, mem_we}, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wdata", mem_wdata, 0);

    // Fill, first reads, wrap of the write pointer.
    ack_delay = 0;
    for (int k = 1; k <= 9; k++) do_record(8'(k * 10), 1'b1, 0, 1'b0);

    // Slow SRAM with a second record during the write.
    ack_delay = 3;
    do_record(8'hA5, 1'b1, 2, 1'b0);

    // Writes only.
    ack_delay = 1;
    do_record(8'h11, 1'b0, 0, 1'b0);
    do_record(8'h22, 1'b0, 0, 1'b0);

    // Flush during a read: read completes, then buffer restarts.
    ack_delay = 2;
    do_record(8'h33, 1'b1, 0, 1'b1);
    ack_delay = 0;
    do_record(8'h44, 1'b1, 0, 1'b0);

    // Flush with a coincident record, then a stray ack while idle.
    do_flush(1'b1);
    @(negedge clk); stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    @(negedge clk);
    check_val("stray_ack", {busy, mem_req}, 0);
    check_val("stray_nowr", wr_addr_q.size() + rd_addr_q.size(), 0);

    for (int k = 0; k < 80; k++) begin
      int r;
      ack_delay = $urandom_range(0, 3);
      r = $urandom_range(0, 19);
      if (r == 0) do_flush(1'($urandom_range(0, 1)));
      do_record(8'($urandom), 1'($urandom_range(0, 1)),
                (r == 1) ? $urandom_range(1, 3) : 0, r == 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
